// File: rtl/sphere3_sched_pkg.sv
// Shared types for the sphere3 request scheduler: FSM states, the captured
// 4-D point and the per-requester sequence index width.
package sphere3_sched_pkg;

  localparam int INDEX_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESEED = 2'd1,
    POP    = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } sphere3_point_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting ID strictly after the
// last granted ID, wrapping. The pointer only moves when advance is high.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  logic [ID_W-1:0] last_q, last_d;

  // Two passes: IDs at or below the pointer first, then IDs above it
  // overwrite, so the lowest ID after the pointer wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) <= last_q)) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) > last_q)) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end

  assign last_d = advance ? grant_id : last_q;

  // Reset to the top ID so the first grant after reset goes to ID 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) last_q <= ID_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/sphere3_req_sched.sv
// Round-robin scheduler sharing one sphere3_32bit generator among NUM_REQ
// requesters. Optional generator timeout: define SPHERE3_SCHED_TIMEOUT_EN.
module sphere3_req_sched
  import sphere3_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
`ifdef SPHERE3_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               cfg_we,
  input  logic [ID_W-1:0]    cfg_id,
  input  logic [31:0]        cfg_index,
  output logic               gen_reseed_enable,
  output logic [31:0]        gen_seed,
  output logic               gen_pop_enable,
  input  logic               gen_valid,
  input  logic [31:0]        gen_x,
  input  logic [31:0]        gen_y,
  input  logic [31:0]        gen_z,
  input  logic [31:0]        gen_w,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_x,
  output logic [31:0]        rsp_y,
  output logic [31:0]        rsp_z,
  output logic [31:0]        rsp_w,
  output logic               rsp_err,
  output logic               busy
);

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    arb_id;
  logic               arb_valid;
  logic               arb_advance;
  logic               capture;
  sphere3_point_t     point_q;
  logic [INDEX_W-1:0] index_q [NUM_REQ];

`ifdef SPHERE3_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout;
  logic            err_q;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .advance     (arb_advance),
    .grant_id    (arb_id),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d           = state_q;
    arb_advance       = 1'b0;
    capture           = 1'b0;
    gen_reseed_enable = 1'b0;
    gen_pop_enable    = 1'b0;
    gen_seed          = '0;
`ifdef SPHERE3_SCHED_TIMEOUT_EN
    timeout           = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          arb_advance = 1'b1;
          state_d     = RESEED;
        end
      end
      RESEED: begin
        gen_reseed_enable = 1'b1;
        gen_seed          = index_q[grant_q];
        state_d           = POP;
      end
      POP: begin
        gen_pop_enable = 1'b1;
        if (gen_valid) begin
          capture = 1'b1;
          state_d = RESP;
        end
`ifdef SPHERE3_SCHED_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      point_q <= '0;
`ifdef SPHERE3_SCHED_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (arb_advance) grant_q <= arb_id;
      if (capture) point_q <= '{x: gen_x, y: gen_y, z: gen_z, w: gen_w};
`ifdef SPHERE3_SCHED_TIMEOUT_EN
      if (timeout) point_q <= '0;
      if (state_q == POP && !gen_valid) to_cnt_q <= to_cnt_q + 1'b1;
      else                              to_cnt_q <= '0;
      if (timeout)                              err_q <= 1'b1;
      else if (state_q == RESP && rsp_ready)    err_q <= 1'b0;
`endif
    end
  end

  // The config write sits after the increment so it wins on a same-edge
  // collision; an out-of-range cfg_id matches no entry and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the index table is small and must clear on reset, so it is built from flops rather than RAM.
      for (int i = 0; i < NUM_REQ; i++) index_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture && grant_q == ID_W'(i)) index_q[i] <= index_q[i] + 1'b1;
        if (cfg_we && cfg_id == ID_W'(i))   index_q[i] <= cfg_index;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = grant_q;
  assign rsp_x     = point_q.x;
  assign rsp_y     = point_q.y;
  assign rsp_z     = point_q.z;
  assign rsp_w     = point_q.w;
  assign busy      = (state_q != IDLE);
`ifdef SPHERE3_SCHED_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
